flash_weight_responder: RTL and testbench



---
 rtl/flash_weight_responder.sv | 109 ++++++++++
 tb/tb_flash_weight_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_weight_responder.sv
// flash_weight_responder: serves 16-bit weight/bias words from an on-chip
// store to the network controller's flash request interface. Each request
// returns its word exactly LATENCY cycles later, one request per cycle, with
// no stall or backpressure.
// Optional feature macro: FLASH_RANGE_CHECK_EN. When it is defined,
// out-of-range reads return zero, out-of-range loads are dropped, and both
// set the sticky addr_err flag. When it is undefined, addresses wrap modulo
// DEPTH, which must then be a power of two.
module flash_weight_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flash_ready,
  input  logic [15:0] flash_address,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  input  logic        clear_err,
  output logic [15:0] flashData_out,
  output logic        data_valid,
  output logic        flash_busy,
  output logic        addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The store is deliberately not reset so weights survive n_rst.
  logic [15:0] mem_q [DEPTH];

  logic [AW-1:0] rd_idx, wr_idx;
  logic          wr_en;
  logic [15:0]   rd_data;
  logic          addr_err_q, addr_err_d;

  // Stage 0 is loaded by the request edge. Stage LATENCY-1 is the output
  // register, so data is registered at edge k+LATENCY-1.
  logic [LATENCY-1:0]       vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][15:0] dat_pipe_q, dat_pipe_d;

`ifdef FLASH_RANGE_CHECK_EN
  logic rd_oor, wr_oor;

  // Range-check addresses; out-of-range reads yield zero and loads are dropped.
  always_comb begin
    rd_oor     = {16'd0, flash_address} >= 32'(DEPTH);
    wr_oor     = {16'd0, load_addr} >= 32'(DEPTH);
    rd_idx     = flash_address[AW-1:0];
    wr_idx     = load_addr[AW-1:0];
    wr_en      = load_en & ~wr_oor;
    rd_data    = rd_oor ? 16'h0000 : mem_q[rd_idx];
    // A set in the same cycle as a clear wins.
    addr_err_d = (flash_ready & rd_oor) | (load_en & wr_oor) |
                 (addr_err_q & ~clear_err);
  end
`else
  // Upper address bits and clear_err have no function when addresses wrap.
  logic unused_in;
  assign unused_in = &{1'b0, clear_err, flash_address, load_addr};

  // Wrap addresses modulo DEPTH; the error flag stays low.
  always_comb begin
    rd_idx     = flash_address[AW-1:0];
    wr_idx     = load_addr[AW-1:0];
    wr_en      = load_en;
    rd_data    = mem_q[rd_idx];
    addr_err_d = 1'b0;
  end
`endif

  // Store write. The read is combinational from the current contents, so a
  // same-cycle read of the written address sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= load_data;
  end

  // Shift the read pipeline. The final stage holds its data between returns.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '0;
    vld_pipe_d[0] = flash_ready;
    dat_pipe_d[0] = rd_data;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
    end
    if (!vld_pipe_d[LATENCY-1]) dat_pipe_d[LATENCY-1] = dat_pipe_q[LATENCY-1];
  end

  // Pipeline and error-flag registers. Reset flushes any in-flight requests.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign flashData_out = dat_pipe_q[LATENCY-1];
  assign data_valid    = vld_pipe_q[LATENCY-1];
  assign flash_busy    = |vld_pipe_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_flash_weight_responder.sv
// Testbench for flash_weight_responder. Requests push their expected word and
// due cycle into a scoreboard; a monitor pops and compares on each data_valid.
module tb_flash_weight_responder;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;

  logic        clk = 1'b0, n_rst = 1'b0;
  logic        flash_ready = 1'b0, load_en = 1'b0, clear_err = 1'b0;
  logic [15:0] flash_address = '0, load_addr = '0, load_data = '0;
  logic [15:0] flashData_out;
  logic        data_valid, flash_busy, addr_err;

  flash_weight_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .n_rst(n_rst), .flash_ready(flash_ready),
    .flash_address(flash_address), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .clear_err(clear_err), .flashData_out(flashData_out),
    .data_valid(data_valid), .flash_busy(flash_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every return against the scoreboard; between returns
  // the output word must hold its last value.
  logic [15:0] last_out = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!n_rst) last_out = '0;
    else if (data_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("data", {16'd0, flashData_out}, {16'd0, e.data});
        chk("latency", cyc, e.due);
        last_out = e.data;
      end
    end else chk("hold", {16'd0, flashData_out}, {16'd0, last_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for the next edge; the caller drops flash_ready.
  task automatic req(input logic [15:0] a, input logic [15:0] expv, input bit push);
    flash_ready   = 1'b1;
    flash_address = a;
    if (push) sb.push_back('{expv, cyc + LATENCY});
    tick();
  endtask

  task automatic idle(input int n);
    flash_ready = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    // Reset, then idle.
    tick(); tick();
    @(negedge clk);
    chk("rst_data", {16'd0, flashData_out}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_busy", {31'd0, flash_busy}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, flash_busy}, 32'd0);
      chk("idle_err", {31'd0, addr_err}, 32'd0);
    end
    tick();

    // Preload the store.
    load(16'd5, 16'h1A2B);
    load(16'd0, 16'h0001);
    load(16'd1, 16'h0002);
    load(16'd2, 16'h0003);
    load(16'd7, 16'h00FF);
    load(16'd88, 16'h5858);

    // Single read: busy for exactly LATENCY cycles.
    req(16'd5, 16'h1A2B, 1'b1);
    flash_ready = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      @(negedge clk);
      chk("single_busy_hi", {31'd0, flash_busy}, 32'd1);
    end
    @(negedge clk);
    chk("single_busy_lo", {31'd0, flash_busy}, 32'd0);
    tick();
    idle(3);

    // Back-to-back reads.
    req(16'd0, 16'h0001, 1'b1);
    req(16'd1, 16'h0002, 1'b1);
    req(16'd2, 16'h0003, 1'b1);
    idle(LATENCY + 4);

    // Same-cycle write and read: old word first, new word next.
    load_en   = 1'b1;
    load_addr = 16'd7;
    load_data = 16'hBEEF;
    req(16'd7, 16'h00FF, 1'b1);
    load_en = 1'b0;
    req(16'd7, 16'hBEEF, 1'b1);
    idle(LATENCY + 4);

    // Out-of-range handling.
`ifdef FLASH_RANGE_CHECK_EN
    req(16'd600, 16'h0000, 1'b1);
    flash_ready = 1'b0;
    @(negedge clk);
    chk("oor_read_err", {31'd0, addr_err}, 32'd1);
    tick();
    idle(LATENCY + 2);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    chk("clear_err", {31'd0, addr_err}, 32'd0);
    tick();
    clear_err = 1'b1;
    req(16'd600, 16'h0000, 1'b1);
    clear_err   = 1'b0;
    flash_ready = 1'b0;
    @(negedge clk);
    chk("set_wins", {31'd0, addr_err}, 32'd1);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    load(16'd600, 16'hDEAD);
    @(negedge clk);
    chk("oor_load_err", {31'd0, addr_err}, 32'd1);
    tick();
    req(16'd88, 16'h5858, 1'b1);
    idle(LATENCY + 4);
`else
    req(16'd600, 16'h5858, 1'b1);
    flash_ready = 1'b0;
    @(negedge clk);
    chk("wrap_err", {31'd0, addr_err}, 32'd0);
    tick();
    idle(LATENCY + 4);
`endif

    // Reset mid-flight: in-flight requests vanish, store survives.
    req(16'd0, 16'h0000, 1'b0);
    req(16'd1, 16'h0000, 1'b0);
    req(16'd2, 16'h0000, 1'b0);
    req(16'd3, 16'h0000, 1'b0);
    idle(3);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, flash_busy}, 32'd0);
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    tick(); tick(); tick();
    n_rst = 1'b1;
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(negedge clk);
      chk("postrst_busy", {31'd0, flash_busy}, 32'd0);
    end
    tick();
    req(16'd2, 16'h0003, 1'b1);
    req(16'd1, 16'h0002, 1'b1);
    idle(LATENCY + 6);

    chk("drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
